// File: rtl/pc_sequencer_if.sv
// Bundle of the program-counter, instruction-memory and execute-unit signals
// seen by pc_sequencer. The master side is the sequencer; the slave side is
// the PC register, instruction memory and decode/execute unit together.
//
// Handshakes:
//   imem_req/imem_ack : imem_req rises on FETCH entry and stays high until the
//     cycle in which imem_ack is sampled high. That cycle is the transfer, and
//     imem_req drops on the next edge. imem_ack outside FETCH is ignored.
//   instr_valid/exec_done : instr_valid pulses for one cycle when the fetched
//     instruction is available. The sequencer then waits for exec_done. br_op,
//     br_taken and br_target are sampled only in the cycle exec_done is high.
//     exec_done outside EXEC is ignored.
// fsm_state and depth expose the controller state and the stack pointer.
interface pc_sequencer_if #(
   parameter int ADDR_W      = 12,
   parameter int STACK_DEPTH = 4
);
   localparam int SP_W = $clog2(STACK_DEPTH);

   logic              run;
   logic [ADDR_W-1:0] pc_q;
   logic              pc_increment;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_req;
   logic              imem_ack;
   logic              instr_valid;
   logic              exec_done;
   logic [1:0]        br_op;
   logic              br_taken;
   logic [ADDR_W-1:0] br_target;
   logic              halted;
   logic              stack_err;
   logic [2:0]        fsm_state;
   logic [SP_W:0]     depth;

   modport master (
      input  run, pc_q, imem_ack, exec_done, br_op, br_taken, br_target,
      output pc_increment, pc_load, pc_d, imem_addr, imem_req, instr_valid,
             halted, stack_err, fsm_state, depth
   );

   modport slave (
      output run, pc_q, imem_ack, exec_done, br_op, br_taken, br_target,
      input  pc_increment, pc_load, pc_d, imem_addr, imem_req, instr_valid,
             halted, stack_err, fsm_state, depth
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch / execute / PC-update controller for a 12-bit program counter with a
// small return-address stack. All outputs are registered except imem_addr.
// The PC action is chosen on the edge that samples exec_done, so the control
// pulse is visible during UPDATE and the new pc_q one cycle later.
module pc_sequencer #(
   parameter int ADDR_W       = 12,
   parameter int STACK_DEPTH  = 4,
   parameter int RESET_VECTOR = 0
) (
   input logic            clk,
   input logic            reset,
   pc_sequencer_if.master bus
);
   localparam int            SP_W    = $clog2(STACK_DEPTH);
   localparam logic [SP_W:0] SP_FULL = (SP_W + 1)'(STACK_DEPTH);
   localparam logic [SP_W:0] SP_ONE  = (SP_W + 1)'(1);

   typedef enum logic [2:0] {
      BOOT   = 3'd0,
      IDLE   = 3'd1,
      FETCH  = 3'd2,
      EXEC   = 3'd3,
      UPDATE = 3'd4,
      HALT   = 3'd5
   } state_t;

   state_t            state, state_n;
   logic [SP_W:0]     sp, sp_n;
   logic [ADDR_W-1:0] stack [STACK_DEPTH];

   logic              inc_q, load_q, req_q, valid_q, halted_q, err_q;
   logic              inc_n, load_n, req_n, valid_n, halted_n, err_n;
   logic [ADDR_W-1:0] pc_d_q, pc_d_n;
   logic              push;
   logic [ADDR_W-1:0] ret_addr;
   logic [SP_W-1:0]   top_idx;

   // Return address wraps naturally at ADDR_W bits (0xFFF pushes 0x000).
   assign ret_addr = bus.pc_q + ADDR_W'(1);
   assign top_idx  = SP_W'(sp - SP_ONE);

   // State, stack pointer and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= BOOT;
         sp       <= '0;
         inc_q    <= 1'b0;
         load_q   <= 1'b0;
         pc_d_q   <= '0;
         req_q    <= 1'b0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_n;
         sp       <= sp_n;
         inc_q    <= inc_n;
         load_q   <= load_n;
         pc_d_q   <= pc_d_n;
         req_q    <= req_n;
         valid_q  <= valid_n;
         halted_q <= halted_n;
         err_q    <= err_n;
      end
   end

   // Return-address storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (push) stack[sp[SP_W-1:0]] <= ret_addr;
   end

   // Next state and next registered output values.
   always_comb begin
      state_n  = state;
      sp_n     = sp;
      inc_n    = 1'b0;
      load_n   = 1'b0;
      pc_d_n   = pc_d_q;
      req_n    = 1'b0;
      valid_n  = 1'b0;
      halted_n = 1'b0;
      err_n    = err_q;
      push     = 1'b0;
      case (state)
         BOOT: begin
            load_n  = 1'b1;
            pc_d_n  = ADDR_W'(RESET_VECTOR);
            state_n = IDLE;
         end
         IDLE: begin
            if (bus.run) begin
               req_n   = 1'b1;
               state_n = FETCH;
            end
         end
         FETCH: begin
            if (bus.imem_ack) begin
               valid_n = 1'b1;
               state_n = EXEC;
            end else begin
               req_n = 1'b1;
            end
         end
         EXEC: begin
            if (bus.exec_done) begin
               state_n = UPDATE;
               case (bus.br_op)
                  2'b00: inc_n = 1'b1;
                  2'b01: begin
                     if (bus.br_taken) begin
                        load_n = 1'b1;
                        pc_d_n = bus.br_target;
                     end else begin
                        inc_n = 1'b1;
                     end
                  end
                  2'b10: begin
                     if (sp < SP_FULL) begin
                        push   = 1'b1;
                        load_n = 1'b1;
                        pc_d_n = bus.br_target;
                        sp_n   = sp + SP_ONE;
                     end else begin
                        err_n = 1'b1;
                     end
                  end
                  default: begin
                     if (sp != '0) begin
                        load_n = 1'b1;
                        pc_d_n = stack[top_idx];
                        sp_n   = sp - SP_ONE;
                     end else begin
                        err_n = 1'b1;
                     end
                  end
               endcase
            end
         end
         UPDATE: begin
            // A stack fault raised on the way into UPDATE ends the program.
            if (err_q) begin
               halted_n = 1'b1;
               state_n  = HALT;
            end else if (bus.run) begin
               req_n   = 1'b1;
               state_n = FETCH;
            end else begin
               state_n = IDLE;
            end
         end
         HALT: halted_n = 1'b1;
         default: state_n = BOOT;
      endcase
   end

   assign bus.pc_increment = inc_q;
   assign bus.pc_load      = load_q;
   assign bus.pc_d         = pc_d_q;
   assign bus.imem_addr    = bus.pc_q;
   assign bus.imem_req     = req_q;
   assign bus.instr_valid  = valid_q;
   assign bus.halted       = halted_q;
   assign bus.stack_err    = err_q;
   assign bus.fsm_state    = state;
   assign bus.depth        = sp;
endmodule
